// File: rtl/uart_flash_loader.sv
// Receives a length-prefixed image over UART, buffers it one 256-byte page at a time and
// drives sector-erase / page-program requests, pacing the host with ACK/NAK bytes.
module uart_flash_loader #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [7:0]  ACK_BYTE  = 8'h06,
  parameter logic [7:0]  NAK_BYTE  = 8'h15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        flash_sector_erase,
  output logic [23:0] flash_sector_addr,
  input  logic        flash_sector_erase_ack,
  output logic        flash_write,
  output logic [23:0] flash_write_addr,
  output logic [8:0]  flash_write_size,
  input  logic        flash_write_data_req,
  output logic [7:0]  flash_write_data_in,
  input  logic        flash_write_ack,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    StIdle, StLen1, StLen2, StRecv, StErase, StProg, StAck, StNak, StDone, StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_hi_q, len_hi_d;
  logic [23:0] remaining_q, remaining_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  wr_ptr_q, wr_ptr_d;
  logic [8:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        erase_q, erase_d;
  logic [23:0] sector_addr_q, sector_addr_d;
  logic        write_q, write_d;
  logic [23:0] write_addr_q, write_addr_d;
  logic [8:0]  write_size_q, write_size_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        mem_we;
  logic [7:0]  page_mem [256];

  always_comb begin
    state_d       = state_q;
    len_hi_d      = len_hi_q;
    remaining_d   = remaining_q;
    addr_d        = addr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    erase_d       = erase_q;
    sector_addr_d = sector_addr_q;
    write_d       = write_q;
    write_addr_d  = write_addr_q;
    write_size_d  = write_size_q;
    wdata_d       = wdata_q;
    done_d        = done_q;
    error_d       = error_q;
    mem_we        = 1'b0;

    // Any byte arriving while the page is being flushed is an overflow.
    if (rx_valid && (state_q inside {StErase, StProg, StAck})) error_d = 1'b1;

    unique case (state_q)
      StIdle: if (rx_valid) begin
        len_hi_d[15:8] = rx_data;
        state_d        = StLen1;
      end
      StLen1: if (rx_valid) begin
        len_hi_d[7:0] = rx_data;
        state_d       = StLen2;
      end
      StLen2: if (rx_valid) begin
        remaining_d = {len_hi_q, rx_data};
        if ({len_hi_q, rx_data} == 24'd0) begin
          state_d    = StAck;
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
        end else begin
          state_d = StRecv;
        end
      end
      StRecv: if (rx_valid) begin
        mem_we      = 1'b1;
        wr_ptr_d    = wr_ptr_q + 9'd1;
        remaining_d = remaining_q - 24'd1;
        if (wr_ptr_d == 9'd256 || remaining_d == 24'd0) begin
          if (addr_q[15:0] == 16'h0000) begin
            state_d       = StErase;
            erase_d       = 1'b1;
            sector_addr_d = {addr_q[23:16], 16'h0000};
          end else begin
            state_d      = StProg;
            write_d      = 1'b1;
            write_addr_d = addr_q;
            write_size_d = wr_ptr_d;
          end
        end
      end
      StErase: if (flash_sector_erase_ack) begin
        erase_d = 1'b0;
        if (error_d) begin
          state_d    = StNak;
          tx_valid_d = 1'b1;
          tx_data_d  = NAK_BYTE;
        end else begin
          state_d      = StProg;
          write_d      = 1'b1;
          write_addr_d = addr_q;
          write_size_d = wr_ptr_q;
        end
      end
      StProg: begin
        // A request coinciding with the ack is still served before the page is closed.
        if (flash_write_data_req && rd_ptr_q < wr_ptr_q) begin
          wdata_d  = page_mem[rd_ptr_q[7:0]];
          rd_ptr_d = rd_ptr_q + 9'd1;
        end
        if (flash_write_ack) begin
          write_d    = 1'b0;
          addr_d     = addr_q + {15'd0, write_size_q};
          wr_ptr_d   = 9'd0;
          rd_ptr_d   = 9'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = error_d ? NAK_BYTE : ACK_BYTE;
          state_d    = error_d ? StNak : StAck;
        end
      end
      StAck: if (tx_ready) begin
        tx_valid_d = 1'b0;
        if (error_d) begin
          state_d    = StNak;
          tx_valid_d = 1'b1;
          tx_data_d  = NAK_BYTE;
        end else if (remaining_q != 24'd0) begin
          state_d = StRecv;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StNak: if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = StErr;
      end
      StDone, StErr: ;
      default: state_d = StIdle;
    endcase

    busy_d = !(state_d inside {StIdle, StDone, StErr});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      len_hi_q      <= '0;
      remaining_q   <= '0;
      addr_q        <= BASE_ADDR;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      erase_q       <= 1'b0;
      sector_addr_q <= '0;
      write_q       <= 1'b0;
      write_addr_q  <= '0;
      write_size_q  <= '0;
      wdata_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_hi_q      <= len_hi_d;
      remaining_q   <= remaining_d;
      addr_q        <= addr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      erase_q       <= erase_d;
      sector_addr_q <= sector_addr_d;
      write_q       <= write_d;
      write_addr_q  <= write_addr_d;
      write_size_q  <= write_size_d;
      wdata_q       <= wdata_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) page_mem[wr_ptr_q[7:0]] <= rx_data;
  end

  assign tx_data             = tx_data_q;
  assign tx_valid            = tx_valid_q;
  assign flash_sector_erase  = erase_q;
  assign flash_sector_addr   = sector_addr_q;
  assign flash_write         = write_q;
  assign flash_write_addr    = write_addr_q;
  assign flash_write_size    = write_size_q;
  assign flash_write_data_in = wdata_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign error               = error_q;

endmodule
